tiny16_io_ctrl: RTL and testbench
=================================

// Module: tiny16_io_ctrl
// PURPOSE
//  IO bus controller between the tiny16 core's IO port and its peripherals.
//  - Decodes each core IO transaction to one of 3 external peripheral windows or an internal register window.
//  - Sequences the valid/ready handshake towards the core, with an optional timeout.
//  - Merges IRQ_LINES edge-triggered sources into the core's single interrupt line (pending/mask/priority).
// PARAMETERS
//  IRQ_LINES   8   number of interrupt sources (1..16)
//  TIMEOUT     15  BUSY cycles without p_ready before abort (1..255)
//  ERR_DATA    16'hDEAD  read data returned on a timed-out read
// PORTS
//  clk              in   1   single clock, all logic on posedge
//  reset            in   1   synchronous, active-high
//  cpu_address      in   8   core IO address
//  cpu_data_out     in   16  core write data
//  cpu_data_in      out  16  read data to core
//  cpu_mem_valid    in   1   core transaction request
//  cpu_nwr          in   1   0 = write, 1 = read
//  cpu_mem_ready    out  1   transaction complete, one-cycle pulse
//  cpu_interrupt    out  1   interrupt request to core
//  cpu_in_interrupt in   1   core is servicing an interrupt
//  p_valid          out  3   one-hot peripheral select; held until that peripheral's p_ready
//  p_nwr            out  1   write strobe polarity as cpu_nwr
//  p_address        out  6   cpu_address[5:0]
//  p_wdata          out  16  write data
//  p_rdata          in   48  {p2,p1,p0} read data, 16 bits each
//  p_ready          in   3   per-peripheral completion
//  irq              in   IRQ_LINES  interrupt sources, level in, rising edge captured
// BEHAVIOUR
//  Reset values
//  - All outputs 0; FSM=IDLE; pending, mask, bus_error, err_win all cleared.
//  - irq edge detector history register set to current irq, so lines already high at reset generate no edge.
//  Decode (cpu_address[7:6])
//  - 0..2: external peripheral n.
//  - 3: internal registers, selected by cpu_address[1:0].
//  FSM states
//  - IDLE: when cpu_mem_valid is sampled high, latch address, data and nwr.
//    - Internal window -> DONE.
//    - External window -> BUSY, with p_valid[n] set on the same edge.
//  - BUSY:
//    - p_ready[n]=1: capture p_rdata[n], clear p_valid -> DONE.
//    - p_ready bits other than n are ignored.
//  - DONE: cpu_mem_ready=1 for exactly this one cycle; cpu_data_in valid in the same cycle -> IDLE.
//    - cpu_data_in holds its value until the next DONE.
//  - A new request is accepted in IDLE the cycle after DONE (back-to-back transactions are allowed).
//  - cpu_mem_valid dropping while in BUSY is ignored; the transaction always completes.
//  Latency (cpu_mem_valid sampled at cycle 0)
//  - Internal: cpu_mem_ready at cycle 1.
//  - External: p_valid at cycle 1; p_ready at cycle k gives cpu_mem_ready at cycle k+1.
//  Internal registers
//  - 0 PENDING: R; W1C. A new edge wins over a same-cycle clear of that bit.
//  - 1 MASK: R/W; bits >= IRQ_LINES read 0.
//  - 2 STATUS: bit0 bus_error (sticky, W1C); bits[9:8] err_win (window index of the last timeout).
//  - 3 VECTOR: RO; bit15 = any (pending & mask); bits[3:0] = lowest set index (bit 0 highest priority).
//  - Write to VECTOR is a no-op.
//  Interrupt output
//  - cpu_interrupt = |(pending & mask) & !cpu_in_interrupt, registered (1-cycle lag).
//  - Pending bits are cleared only by software W1C.
//  Reset asserted mid-transaction: immediate return to IDLE, p_valid dropped, no cpu_mem_ready.
// CONFIGURATION
//  TINY16_IO_TIMEOUT_EN defined:
//  - An 8-bit counter runs in BUSY.
//  - After TIMEOUT cycles without p_ready: clear p_valid, set bus_error, err_win=n, -> DONE.
//    - A read returns ERR_DATA; a write is discarded.
//  - p_ready arriving in the same cycle as expiry counts as success.
//  TINY16_IO_TIMEOUT_EN undefined:
//  - BUSY waits indefinitely; bus_error and err_win stay 0; ERR_DATA is unused.
// STRUCTURE
//  Package tiny16_io_pkg:
//  - FSM state enum {IDLE,BUSY,DONE}.
//  - Window indices and internal register offsets (REG_PENDING..REG_VECTOR).
//  - Default ERR_DATA.
//  Sub-module tiny16_irq_ctrl:
//  - Edge detect, pending/mask registers, priority encoder, cpu_interrupt generation.
//  - Interface: W1C/mask write port and read bus.
//  Top holds the FSM, decode, timeout counter and data muxing.
// TESTING
//  1. Write MASK: addr 0xC1, data 0x0005 -> cpu_mem_ready at cycle 1; read 0xC1 returns 0x0005.
//  2. Read addr 0x45 with p_ready[1] at cycle 3, p_rdata[1]=0x1234 ->
//     p_valid=3'b010, p_address=5 on cycles 1-3; cpu_mem_ready at cycle 4; cpu_data_in=0x1234.
//  3. irq[2] and irq[0] rising together, MASK=0x5 -> cpu_interrupt=1 one cycle later; VECTOR=0x8000.
//     Set cpu_in_interrupt=1 -> cpu_interrupt=0.
//     W1C PENDING 0x1 -> VECTOR=0x8002.
//  4. irq[0] edge in the same cycle as W1C of PENDING bit0 -> bit0 remains set.
//  5. TIMEOUT_EN, TIMEOUT=15, read addr 0x80, p_ready never asserted ->
//     cpu_mem_ready at cycle 17; data 0xDEAD; STATUS=0x0201.
//     W1C STATUS 0x1 -> STATUS bit0 reads 0.
//  6. Reset asserted at cycle 2 of the external read in test 2 ->
//     p_valid=0 next cycle; no cpu_mem_ready; MASK=0.

Source files
------------

// File: rtl/tiny16_io_pkg.sv
// tiny16_io_pkg
//   Shared definitions for the tiny16 IO bus controller:
//   - state_e      : controller FSM states (IDLE, BUSY, DONE)
//   - WIN_*        : address windows decoded from cpu_address[7:6]
//   - REG_*        : internal register offsets, cpu_address[1:0] in window 3
//   - ERR_DATA_DEFAULT : read data returned by a timed-out read
//   - lowest_set() : index of the lowest set bit (bit 0 has highest priority)
package tiny16_io_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] WIN_P0  = 2'd0;
   localparam logic [1:0] WIN_P1  = 2'd1;
   localparam logic [1:0] WIN_P2  = 2'd2;
   localparam logic [1:0] WIN_INT = 2'd3;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_VECTOR  = 2'd3;

   localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

   // Scans from the top so the last hit (the lowest index) wins.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/tiny16_io_ctrl_if.sv
// tiny16_io_ctrl_if
//   Core-side IO port of the tiny16 IO bus controller.
//   Signals:
//     cpu_address[7:0], cpu_data_out[15:0], cpu_mem_valid, cpu_nwr,
//     cpu_in_interrupt                  : driven by the core (master)
//     cpu_data_in[15:0], cpu_mem_ready,
//     cpu_interrupt                     : driven by the controller (slave)
//   Handshake: the core raises cpu_mem_valid with address, data and nwr
//   (0 = write, 1 = read) stable; the controller samples it only while
//   idle and latches the request on that edge. Completion is signalled by
//   a single-cycle cpu_mem_ready pulse, with cpu_data_in valid in that same
//   cycle. Once accepted, a transaction always completes, whatever the core
//   does with cpu_mem_valid afterwards.
interface tiny16_io_ctrl_if;

   logic [7:0]  cpu_address;
   logic [15:0] cpu_data_out;
   logic [15:0] cpu_data_in;
   logic        cpu_mem_valid;
   logic        cpu_nwr;
   logic        cpu_mem_ready;
   logic        cpu_interrupt;
   logic        cpu_in_interrupt;

   modport master (
      output cpu_address, cpu_data_out, cpu_mem_valid, cpu_nwr, cpu_in_interrupt,
      input  cpu_data_in, cpu_mem_ready, cpu_interrupt
   );

   modport slave (
      input  cpu_address, cpu_data_out, cpu_mem_valid, cpu_nwr, cpu_in_interrupt,
      output cpu_data_in, cpu_mem_ready, cpu_interrupt
   );

endinterface

// File: rtl/tiny16_irq_ctrl.sv
// tiny16_irq_ctrl
//   Interrupt merger: rising-edge capture of irq into PENDING, MASK register,
//   lowest-index priority encoder (VECTOR) and the registered interrupt line.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     irq_i             : level interrupt sources, rising edges captured
//     in_interrupt_i    : core is servicing an interrupt (suppresses output)
//     wr_en_i, wr_addr_i, wr_data_i : register write port (PENDING is W1C)
//     rd_addr_i, rd_data_o          : register read bus (STATUS reads 0 here)
//     interrupt_o       : |(pending & mask) & !in_interrupt, one cycle late
module tiny16_irq_ctrl
   import tiny16_io_pkg::*;
#(
   parameter int IRQ_LINES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IRQ_LINES-1:0] irq_i,
   input  logic                 in_interrupt_i,
   input  logic                 wr_en_i,
   input  logic [1:0]           wr_addr_i,
   input  logic [IRQ_LINES-1:0] wr_data_i,
   input  logic [1:0]           rd_addr_i,
   output logic [15:0]          rd_data_o,
   output logic                 interrupt_o
);

   logic [IRQ_LINES-1:0] irq_hist_q;
   logic [IRQ_LINES-1:0] pending_q;
   logic [IRQ_LINES-1:0] pending_d;
   logic [IRQ_LINES-1:0] mask_q;
   logic [IRQ_LINES-1:0] irq_edge;
   logic [IRQ_LINES-1:0] pend_clr;
   logic [15:0]          pend16;
   logic [15:0]          mask16;
   logic [15:0]          active16;
   logic [15:0]          vector16;
   logic                 interrupt_q;

   assign irq_edge = irq_i & ~irq_hist_q;
   assign pend_clr = (wr_en_i && (wr_addr_i == REG_PENDING)) ? wr_data_i : '0;
   // Edge is OR-ed in after the clear, so a new edge beats a same-cycle W1C.
   assign pending_d = (pending_q & ~pend_clr) | irq_edge;

   always_comb begin
      pend16 = '0;
      mask16 = '0;
      pend16[IRQ_LINES-1:0] = pending_q;
      mask16[IRQ_LINES-1:0] = mask_q;
   end

   assign active16 = pend16 & mask16;
   assign vector16 = {|active16, 11'd0, lowest_set(active16)};

   always_comb begin
      rd_data_o = '0;
      case (rd_addr_i)
         REG_PENDING: rd_data_o = pend16;
         REG_MASK:    rd_data_o = mask16;
         REG_VECTOR:  rd_data_o = vector16;
         default:     rd_data_o = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // History starts at the live level: lines already high raise no edge.
         irq_hist_q  <= irq_i;
         pending_q   <= '0;
         mask_q      <= '0;
         interrupt_q <= 1'b0;
      end else begin
         irq_hist_q  <= irq_i;
         pending_q   <= pending_d;
         if (wr_en_i && (wr_addr_i == REG_MASK)) mask_q <= wr_data_i;
         interrupt_q <= (|active16) & ~in_interrupt_i;
      end
   end

   assign interrupt_o = interrupt_q;

endmodule

// File: rtl/tiny16_io_ctrl.sv
// tiny16_io_ctrl
//   IO bus controller between the tiny16 core IO port and its peripherals.
//   cpu_address[7:6] selects peripheral 0..2 or the internal register window
//   (3), where cpu_address[1:0] picks PENDING / MASK / STATUS / VECTOR.
//   Optional feature macro: TINY16_IO_TIMEOUT_EN -- when defined, a BUSY
//   phase that sees no p_ready for TIMEOUT cycles is aborted: bus_error is
//   set, err_win records the window, and a read returns ERR_DATA.
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     cpu            : core IO port (tiny16_io_ctrl_if.slave)
//     p_valid[2:0]   : one-hot peripheral select, held until its p_ready
//     p_nwr, p_address[5:0], p_wdata[15:0] : latched request to peripheral
//     p_rdata[47:0]  : {p2,p1,p0} read data
//     p_ready[2:0]   : per-peripheral completion
//     irq            : interrupt sources
//     dbg_state_o    : current FSM state
module tiny16_io_ctrl
   import tiny16_io_pkg::*;
#(
   parameter int          IRQ_LINES = 8,
   parameter int          TIMEOUT   = 15,
   parameter logic [15:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   tiny16_io_ctrl_if.slave      cpu,
   output logic [2:0]           p_valid,
   output logic                 p_nwr,
   output logic [5:0]           p_address,
   output logic [15:0]          p_wdata,
   input  logic [47:0]          p_rdata,
   input  logic [2:0]           p_ready,
   input  logic [IRQ_LINES-1:0] irq,
   output state_e               dbg_state_o
);

   state_e      state_q;
   logic [1:0]  win_q;
   logic        ready_q;
   logic [15:0] data_in_q;
   logic        bus_error_q;
   logic [1:0]  err_win_q;

   logic        req_int;
   logic        int_wr;
   logic [1:0]  reg_sel;
   logic        sel_ready;
   logic [15:0] sel_rdata;
   logic        expire;
   logic [15:0] irq_rdata;
   logic [15:0] int_rdata;
   logic        irq_out;

   assign reg_sel = cpu.cpu_address[1:0];
   assign req_int = (state_q == IDLE) && cpu.cpu_mem_valid &&
                    (cpu.cpu_address[7:6] == WIN_INT);
   assign int_wr  = req_int && !cpu.cpu_nwr;

   // Only the addressed peripheral's ready/data matter; the others are ignored.
   always_comb begin
      sel_ready = p_ready[0];
      sel_rdata = p_rdata[15:0];
      case (win_q)
         WIN_P1: begin
            sel_ready = p_ready[1];
            sel_rdata = p_rdata[31:16];
         end
         WIN_P2: begin
            sel_ready = p_ready[2];
            sel_rdata = p_rdata[47:32];
         end
         default: begin
            sel_ready = p_ready[0];
            sel_rdata = p_rdata[15:0];
         end
      endcase
   end

`ifdef TINY16_IO_TIMEOUT_EN
   logic [7:0] tmo_cnt_q;

   // Counts BUSY cycles from 0; expiry is the cycle in which it reads TIMEOUT.
   always_ff @(posedge clk) begin
      if (reset || (state_q != BUSY)) begin
         tmo_cnt_q <= '0;
      end else if (tmo_cnt_q != 8'(TIMEOUT)) begin
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
   end

   assign expire = (state_q == BUSY) && (tmo_cnt_q == 8'(TIMEOUT));
`else
   logic [7:0] timeout_unused;

   // Without the timeout BUSY waits forever; TIMEOUT is kept referenced only.
   assign timeout_unused = 8'(TIMEOUT);
   assign expire         = 1'b0;
`endif

   assign int_rdata = (reg_sel == REG_STATUS) ?
                      {6'd0, err_win_q, 7'd0, bus_error_q} : irq_rdata;

   tiny16_irq_ctrl #(
      .IRQ_LINES (IRQ_LINES)
   ) u_irq (
      .clk            (clk),
      .reset          (reset),
      .irq_i          (irq),
      .in_interrupt_i (cpu.cpu_in_interrupt),
      .wr_en_i        (int_wr),
      .wr_addr_i      (reg_sel),
      .wr_data_i      (cpu.cpu_data_out[IRQ_LINES-1:0]),
      .rd_addr_i      (reg_sel),
      .rd_data_o      (irq_rdata),
      .interrupt_o    (irq_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         win_q       <= WIN_P0;
         ready_q     <= 1'b0;
         data_in_q   <= '0;
         bus_error_q <= 1'b0;
         err_win_q   <= '0;
         p_valid     <= '0;
         p_nwr       <= 1'b0;
         p_address   <= '0;
         p_wdata     <= '0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu.cpu_mem_valid) begin
                  win_q     <= cpu.cpu_address[7:6];
                  p_nwr     <= cpu.cpu_nwr;
                  p_address <= cpu.cpu_address[5:0];
                  p_wdata   <= cpu.cpu_data_out;
                  if (req_int) begin
                     // Internal access completes on this edge; read data is
                     // captured now so it is valid alongside the ready pulse.
                     state_q <= DONE;
                     ready_q <= 1'b1;
                     if (cpu.cpu_nwr) data_in_q <= int_rdata;
                     if (int_wr && (reg_sel == REG_STATUS) && cpu.cpu_data_out[0])
                        bus_error_q <= 1'b0;
                  end else begin
                     state_q <= BUSY;
                     p_valid <= 3'b001 << cpu.cpu_address[7:6];
                  end
               end
            end
            BUSY: begin
               // A ready in the expiry cycle is checked first and wins.
               if (sel_ready) begin
                  if (p_nwr) data_in_q <= sel_rdata;
                  p_valid <= '0;
                  state_q <= DONE;
                  ready_q <= 1'b1;
               end else if (expire) begin
                  if (p_nwr) data_in_q <= ERR_DATA;
                  p_valid     <= '0;
                  bus_error_q <= 1'b1;
                  err_win_q   <= win_q;
                  state_q     <= DONE;
                  ready_q     <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cpu.cpu_data_in   = data_in_q;
   assign cpu.cpu_mem_ready = ready_q;
   assign cpu.cpu_interrupt = irq_out;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_tiny16_io_ctrl.sv
// tb_tiny16_io_ctrl
//   Self-checking bench for tiny16_io_ctrl (IRQ_LINES=8, TIMEOUT=15,
//   ERR_DATA=16'hDEAD). Cycle numbering: cycle 0 is the clock period whose
//   closing edge samples cpu_mem_valid; cycle k is the k-th period after it.
module tb_tiny16_io_ctrl;
  import tiny16_io_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  cpu_address;
  logic [15:0] cpu_data_out;
  logic        cpu_mem_valid;
  logic        cpu_nwr;
  logic        cpu_in_interrupt;
  logic [47:0] p_rdata;
  logic [2:0]  p_ready;
  logic [7:0]  irq;
  logic [2:0]  p_valid;
  logic        p_nwr;
  logic [5:0]  p_address;
  logic [15:0] p_wdata;
  state_e      dbg_state;
  wire [15:0]  cpu_data_in   = cpu_bus.cpu_data_in;
  wire         cpu_mem_ready = cpu_bus.cpu_mem_ready;
  wire         cpu_interrupt = cpu_bus.cpu_interrupt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  tiny16_io_ctrl_if cpu_bus();
  assign cpu_bus.cpu_address      = cpu_address;
  assign cpu_bus.cpu_data_out     = cpu_data_out;
  assign cpu_bus.cpu_mem_valid    = cpu_mem_valid;
  assign cpu_bus.cpu_nwr          = cpu_nwr;
  assign cpu_bus.cpu_in_interrupt = cpu_in_interrupt;

  tiny16_io_ctrl #(.IRQ_LINES(8), .TIMEOUT(15), .ERR_DATA(16'hDEAD)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (cpu_bus),
    .p_valid     (p_valid),
    .p_nwr       (p_nwr),
    .p_address   (p_address),
    .p_wdata     (p_wdata),
    .p_rdata     (p_rdata),
    .p_ready     (p_ready),
    .irq         (irq),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver ----------------
  // One core transaction. rdy_cyc < 0 means the peripheral never answers.
  // irq_or is OR-ed onto irq in cycle 0 (same cycle the request is sampled).
  task automatic cpu_txn(input logic [7:0] a, input logic [15:0] wd, input logic rd,
                         input int rdy_cyc, input logic [15:0] prd, input logic [7:0] irq_or,
                         output int lat, output logic [15:0] dout, output int pv_bad,
                         output logic [2:0] pv_done, output logic [15:0] pw_seen,
                         output logic pn_seen);
    int win;
    win = int'(a[7:6]);
    lat = -1; dout = 'x; pv_bad = 0; pv_done = 'x; pw_seen = 'x; pn_seen = 'x;
    @(negedge clk);
    p_rdata       = {16'($urandom), 16'($urandom), 16'($urandom)};
    cpu_address   = a;
    cpu_data_out  = wd;
    cpu_nwr       = rd;
    cpu_mem_valid = 1'b1;
    irq           = irq | irq_or;
    for (int p = 1; p <= 60; p++) begin
      @(negedge clk);
      cpu_mem_valid = 1'b0;
      p_ready       = 3'b000;
      if (cpu_mem_ready) begin
        lat = p; dout = cpu_data_in; pv_done = p_valid;
        break;
      end
      if (win != 3) begin
        if (p_valid !== 3'(1 << win) || p_address !== a[5:0]) pv_bad++;
        if (p == 1) begin pw_seen = p_wdata; pn_seen = p_nwr; end
        // Stray ready from a different peripheral must be ignored.
        if (p == 1 && rdy_cyc != 1) p_ready[(win + 1) % 3] = 1'b1;
        if (p == rdy_cyc) begin
          p_ready[win] = 1'b1;
          p_rdata[win*16 +: 16] = prd;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat, pvb; logic [15:0] d, e, pw; logic [2:0] pvd; logic pn;
    n_cmp++; if (cpu_mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", cpu_mem_ready); end
    n_cmp++; if (p_valid !== 3'b000) begin n_bad++; $display("FAIL reset_p_valid: got %b expected 000", p_valid); end
    n_cmp++; if (cpu_interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_irq_out: got %b expected 0", cpu_interrupt); end
    n_cmp++; if (cpu_data_in !== 16'h0000) begin n_bad++; $display("FAIL reset_data_in: got %h expected 0000", cpu_data_in); end
    n_cmp++; if ({p_nwr, p_address, p_wdata} !== 23'd0) begin n_bad++; $display("FAIL reset_p_bus: got %h expected 0", {p_nwr, p_address, p_wdata}); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    // irq[7] was high through reset: no pending edge.
    exp_q.push_back(16'h0000);
    cpu_txn(8'hC0, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL reset_pending: got %h expected %h", d, e); end
  endtask

  task automatic test_internal();
    int lat, pvb; logic [15:0] d, e, pw; logic [2:0] pvd; logic pn;
    cpu_txn(8'hC1, 16'h0005, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mask_wr_latency: got %0d expected 1", lat); end
    @(negedge clk);
    n_cmp++; if (cpu_mem_ready !== 1'b0) begin n_bad++; $display("FAIL ready_pulse_width: got %b expected 0", cpu_mem_ready); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL state_after_done: got %0d expected %0d", dbg_state, IDLE); end
    exp_q.push_back(16'h0005);
    cpu_txn(8'hC1, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mask_rd_latency: got %0d expected 1", lat); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL mask_rd: got %h expected %h", d, e); end
    cpu_txn(8'hC1, 16'hFFFF, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    cpu_txn(8'hC3, 16'hFFFF, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    exp_q.push_back(16'h00FF);
    cpu_txn(8'hC1, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL mask_upper_bits: got %h expected %h", d, e); end
    exp_q.push_back(16'h0000);
    cpu_txn(8'hC3, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL vector_idle: got %h expected %h", d, e); end
    cpu_txn(8'hC1, 16'h0005, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
  endtask

  task automatic test_ext();
    int lat, pvb; logic [15:0] d, e, pw; logic [2:0] pvd; logic pn;
    exp_q.push_back(16'h1234);
    cpu_txn(8'h45, 16'h0, 1'b1, 3, 16'h1234, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ext_rd_latency: got %0d expected 4", lat); end
    n_cmp++; if (pvb !== 0) begin n_bad++; $display("FAIL ext_rd_p_valid_addr: got %0d bad cycles expected 0", pvb); end
    n_cmp++; if (pvd !== 3'b000) begin n_bad++; $display("FAIL ext_rd_p_valid_done: got %b expected 000", pvd); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL ext_rd_data: got %h expected %h", d, e); end
    repeat (3) @(negedge clk);
    n_cmp++; if (cpu_data_in !== 16'h1234) begin n_bad++; $display("FAIL data_in_hold: got %h expected 1234", cpu_data_in); end
    cpu_txn(8'h8A, 16'hBEEF, 1'b0, 1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ext_wr_latency: got %0d expected 2", lat); end
    n_cmp++; if ({pn, pw} !== {1'b0, 16'hBEEF}) begin n_bad++; $display("FAIL ext_wr_bus: got %h expected 0BEEF", {pn, pw}); end
    n_cmp++; if (pvb !== 0) begin n_bad++; $display("FAIL ext_wr_p_valid_addr: got %0d bad cycles expected 0", pvb); end
  endtask

  task automatic test_irq();
    int lat, pvb; logic [15:0] d, e, pw; logic [2:0] pvd; logic pn;
    @(negedge clk);
    irq[0] = 1'b1; irq[2] = 1'b1;
    @(negedge clk);
    n_cmp++; if (cpu_interrupt !== 1'b0) begin n_bad++; $display("FAIL irq_lag: got %b expected 0", cpu_interrupt); end
    @(negedge clk);
    n_cmp++; if (cpu_interrupt !== 1'b1) begin n_bad++; $display("FAIL irq_assert: got %b expected 1", cpu_interrupt); end
    exp_q.push_back(16'h8000);
    cpu_txn(8'hC3, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL vector_both: got %h expected %h", d, e); end
    exp_q.push_back(16'h0005);
    cpu_txn(8'hC0, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL pending_both: got %h expected %h", d, e); end
    @(negedge clk);
    cpu_in_interrupt = 1'b1;
    @(negedge clk);
    n_cmp++; if (cpu_interrupt !== 1'b0) begin n_bad++; $display("FAIL irq_in_service: got %b expected 0", cpu_interrupt); end
    cpu_txn(8'hC0, 16'h0001, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    exp_q.push_back(16'h8002);
    cpu_txn(8'hC3, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL vector_after_w1c: got %h expected %h", d, e); end
    cpu_in_interrupt = 1'b0;
    cpu_txn(8'hC0, 16'h0004, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    exp_q.push_back(16'h0000);
    cpu_txn(8'hC0, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL pending_cleared: got %h expected %h", d, e); end
    n_cmp++; if (cpu_interrupt !== 1'b0) begin n_bad++; $display("FAIL irq_deassert: got %b expected 0", cpu_interrupt); end
  endtask

  task automatic test_edge_vs_clear();
    int lat, pvb; logic [15:0] d, e, pw; logic [2:0] pvd; logic pn;
    @(negedge clk);
    irq[0] = 1'b0;
    @(negedge clk);
    // irq[0] rises in the same cycle the W1C of bit 0 is sampled.
    cpu_txn(8'hC0, 16'h0001, 1'b0, -1, 16'h0, 8'h01, lat, d, pvb, pvd, pw, pn);
    exp_q.push_back(16'h0001);
    cpu_txn(8'hC0, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL edge_beats_clear: got %h expected %h", d, e); end
    cpu_txn(8'hC0, 16'h0001, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    exp_q.push_back(16'h0000);
    cpu_txn(8'hC0, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL w1c_after_edge: got %h expected %h", d, e); end
  endtask

  task automatic test_back_to_back();
    int lat, pvb, rdy; logic [15:0] d, e, pw, pd; logic [2:0] pvd; logic pn; logic [1:0] w;
    cpu_txn(8'hC1, 16'h0003, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    for (int i = 0; i < 5; i++) begin
      w   = 2'($urandom_range(0, 2));
      pd  = 16'($urandom);
      rdy = $urandom_range(1, 6);
      exp_q.push_back(pd);
      cpu_txn({w, 6'($urandom)}, 16'h0, 1'b1, rdy, pd, 8'h00, lat, d, pvb, pvd, pw, pn);
      e = exp_q.pop_front();
      n_cmp++; if (lat !== rdy + 1) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, rdy + 1); end
      n_cmp++; if (d !== e) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, d, e); end
    end
    exp_q.push_back(16'h0003);
    cpu_txn(8'hC1, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL b2b_mask: got %h expected %h", d, e); end
  endtask

  task automatic test_timeout();
    int lat, pvb; logic [15:0] d, e, pw; logic [2:0] pvd; logic pn;
`ifdef TINY16_IO_TIMEOUT_EN
    exp_q.push_back(16'hDEAD);
    cpu_txn(8'h80, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL tmo_latency: got %0d expected 17", lat); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL tmo_data: got %h expected %h", d, e); end
    n_cmp++; if (pvd !== 3'b000) begin n_bad++; $display("FAIL tmo_p_valid: got %b expected 000", pvd); end
    exp_q.push_back(16'h0201);
    cpu_txn(8'hC2, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL tmo_status: got %h expected %h", d, e); end
    cpu_txn(8'hC2, 16'h0001, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    exp_q.push_back(16'h0200);
    cpu_txn(8'hC2, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL status_w1c: got %h expected %h", d, e); end
    // Ready in the expiry cycle counts as success.
    exp_q.push_back(16'h4242);
    cpu_txn(8'h40, 16'h0, 1'b1, 16, 16'h4242, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL tmo_edge_latency: got %0d expected 17", lat); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL tmo_edge_data: got %h expected %h", d, e); end
    cpu_txn(8'h55, 16'h1111, 1'b0, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    exp_q.push_back(16'h0101);
    cpu_txn(8'hC2, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL tmo_wr_status: got %h expected %h", d, e); end
`else
    exp_q.push_back(16'h7777);
    cpu_txn(8'h80, 16'h0, 1'b1, 30, 16'h7777, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 31) begin n_bad++; $display("FAIL long_wait_latency: got %0d expected 31", lat); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL long_wait_data: got %h expected %h", d, e); end
    n_cmp++; if (pvb !== 0) begin n_bad++; $display("FAIL long_wait_p_valid: got %0d bad cycles expected 0", pvb); end
    exp_q.push_back(16'h0000);
    cpu_txn(8'hC2, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL status_zero: got %h expected %h", d, e); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, pvb, seen; logic [15:0] d, e, pw; logic [2:0] pvd; logic pn;
    seen = 0;
    @(negedge clk);
    cpu_address = 8'h45; cpu_nwr = 1'b1; cpu_mem_valid = 1'b1;
    @(negedge clk);                       // cycle 1
    cpu_mem_valid = 1'b0;
    n_cmp++; if (p_valid !== 3'b010) begin n_bad++; $display("FAIL rst_mid_p_valid_pre: got %b expected 010", p_valid); end
    @(negedge clk);                       // cycle 2
    reset = 1'b1;
    @(negedge clk);                       // cycle 3
    n_cmp++; if (p_valid !== 3'b000) begin n_bad++; $display("FAIL rst_mid_p_valid: got %b expected 000", p_valid); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, IDLE); end
    if (cpu_mem_ready) seen++;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_mem_ready) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_no_ready: got %0d pulses expected 0", seen); end
    exp_q.push_back(16'h0000);
    cpu_txn(8'hC1, 16'h0, 1'b1, -1, 16'h0, 8'h00, lat, d, pvb, pvd, pw, pn);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rst_mid_mask: got %h expected %h", d, e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; cpu_address = '0; cpu_data_out = '0; cpu_mem_valid = 1'b0;
    cpu_nwr = 1'b0; cpu_in_interrupt = 1'b0; p_rdata = '0; p_ready = '0;
    irq = 8'h80;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_internal();
    test_ext();
    test_irq();
    test_edge_vs_clear();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
